mdu_sequencer: RTL and testbench

- Iterative multiply/divide controller beside the main ALU in the pipelined MIPS32 core.
- The EX stage hands it MULT/MULTU/DIV/DIVU operations, selected by the 6-bit ALU control code from the ALU decoder.
- It sequences a 32-iteration shift-add or restoring-divide datapath and owns the HI/LO registers.
- It raises a stall request so the pipeline holds while a result is pending.

---
 rtl/mdu_pkg.sv | 21 ++
 rtl/mdu_step.sv | 34 +++
 rtl/mdu_sequencer.sv | 120 ++++++++++++
 tb/tb_mdu_sequencer.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared encodings for the multiply/divide sequencer: op codes, FSM states
// and the decoded operation type.
package mdu_pkg;

    localparam logic [5:0] MDU_OP_MULT  = 6'h18;
    localparam logic [5:0] MDU_OP_MULTU = 6'h19;
    localparam logic [5:0] MDU_OP_DIV   = 6'h1A;
    localparam logic [5:0] MDU_OP_DIVU  = 6'h1B;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    typedef struct packed {
        logic is_div;
        logic is_signed;
    } op_t;

endpackage

// File: rtl/mdu_step.sv
// One combinational iteration: shift-add multiply or restoring divide on a
// 2*WIDTH accumulator laid out as {hi_part, lo_part}.
module mdu_step #(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   operand,
    input  logic               is_div,
    output logic [2*WIDTH-1:0] acc_next,
    output logic               qbit
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH+1:0] diff;
    logic [WIDTH-1:0] rem_new;

    always_comb begin
        sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? operand : {WIDTH{1'b0}})};
        rem_sh  = acc[2*WIDTH-1:WIDTH-1];
        // Extra guard bit so a zero divisor never reads as a borrow.
        diff    = {1'b0, rem_sh} - {2'b00, operand};
        qbit    = 1'b0;
        rem_new = rem_sh[WIDTH-1:0];
        if (is_div) begin
            qbit     = ~diff[WIDTH+1];
            rem_new  = qbit ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
            acc_next = {rem_new, acc[WIDTH-2:0], 1'b0};
        end else begin
            acc_next = {sum, acc[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/mdu_sequencer.sv
// Iterative MULT/MULTU/DIV/DIVU controller owning HI/LO; holds the pipeline
// through stall while a result is pending.
module mdu_sequencer
    import mdu_pkg::*;
#(
    parameter int         WIDTH    = 32,
    parameter logic [5:0] OP_MULT  = MDU_OP_MULT,
    parameter logic [5:0] OP_MULTU = MDU_OP_MULTU,
    parameter logic [5:0] OP_DIV   = MDU_OP_DIV,
    parameter logic [5:0] OP_DIVU  = MDU_OP_DIVU
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [5:0]       alu_ctrl,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    input  logic             hilo_rd,
    input  logic             flush,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH) + 1;

    state_t             state, next_state;
    logic [CW-1:0]      count;
    logic [2*WIDTH-1:0] acc, acc_next, prod_fix;
    logic [WIDTH-1:0]   opnd, rs_mag, rt_mag, quo_fix, rem_fix;
    op_t                op, dec_op;
    logic               dec_valid, accept, qbit, sign_a, sign_b, div_zero;

    always_comb begin
        dec_valid = 1'b1;
        dec_op    = '0;
        case (alu_ctrl)
            OP_MULT:  dec_op = '{is_div: 1'b0, is_signed: 1'b1};
            OP_MULTU: dec_op = '{is_div: 1'b0, is_signed: 1'b0};
            OP_DIV:   dec_op = '{is_div: 1'b1, is_signed: 1'b1};
            OP_DIVU:  dec_op = '{is_div: 1'b1, is_signed: 1'b0};
            default:  dec_valid = 1'b0;
        endcase
    end

    // Handshake: an op transfers on a cycle with start=1 while busy=0. While
    // busy, stall holds EX, and any start seen then is dropped and re-presented.
    assign accept = (state == IDLE) && start && dec_valid && !flush;
    assign stall  = busy & (hilo_rd | start);
    assign rs_mag = (dec_op.is_signed && rs_val[WIDTH-1]) ? -rs_val : rs_val;
    assign rt_mag = (dec_op.is_signed && rt_val[WIDTH-1]) ? -rt_val : rt_val;

    always_comb begin
        next_state = state;
        if (flush) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE:    if (accept) next_state = CALC;
                CALC:    if (count == CW'(WIDTH - 1)) next_state = FIX;
                FIX:     next_state = IDLE;
                default: next_state = IDLE;
            endcase
        end
    end

    mdu_step #(.WIDTH(WIDTH)) u_step (
        .acc      (acc),
        .operand  (opnd),
        .is_div   (op.is_div),
        .acc_next (acc_next),
        .qbit     (qbit)
    );

    // Signed x/0 negates the |x| remainder back to x; the quotient stays all ones.
    assign div_zero = (opnd == '0);
    assign prod_fix = (op.is_signed && (sign_a ^ sign_b)) ? -acc : acc;
    assign quo_fix  = (op.is_signed && (sign_a ^ sign_b) && !div_zero)
                      ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    assign rem_fix  = (op.is_signed && sign_a) ? -acc[2*WIDTH-1:WIDTH]
                                               : acc[2*WIDTH-1:WIDTH];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            count  <= '0;
            acc    <= '0;
            opnd   <= '0;
            op     <= '0;
            sign_a <= 1'b0;
            sign_b <= 1'b0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            state <= next_state;
            busy  <= (next_state != IDLE);
            done  <= 1'b0;
            if (accept) begin
                count  <= '0;
                acc    <= {{WIDTH{1'b0}}, rs_mag};
                opnd   <= rt_mag;
                op     <= dec_op;
                sign_a <= rs_val[WIDTH-1];
                sign_b <= rt_val[WIDTH-1];
            end else if (state == CALC && !flush) begin
                acc   <= {acc_next[2*WIDTH-1:1], acc_next[0] | qbit};
                count <= count + CW'(1);
            end else if (state == FIX && !flush) begin
                hi   <= op.is_div ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
                lo   <= op.is_div ? quo_fix : prod_fix[WIDTH-1:0];
                done <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mdu_sequencer.sv
// Scenario bench for mdu_sequencer: expected HI/LO pairs are queued when an
// op is driven and popped when done pulses.
module tb_mdu_sequencer;
    import mdu_pkg::*;

    localparam int W = 32;

    logic         clk, rst_n, start, hilo_rd, flush;
    logic [5:0]   alu_ctrl;
    logic [W-1:0] rs_val, rt_val;
    logic         busy, stall, done;
    logic [W-1:0] hi, lo;

    logic [2*W-1:0] exp_q[$];
    logic [2*W-1:0] exp_v;
    int checks, failures;
    int cycles, busy_cycles;
    bit timed_out;

    mdu_sequencer #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .alu_ctrl(alu_ctrl),
        .rs_val(rs_val), .rt_val(rt_val), .hilo_rd(hilo_rd), .flush(flush),
        .busy(busy), .stall(stall), .done(done), .hi(hi), .lo(lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [2*W-1:0] model(input logic [5:0] c, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
        logic signed [2*W-1:0] pa, pb;
        logic signed [W-1:0]   sa, sb, q, r;
        pa = {{W{a[W-1]}}, a};
        pb = {{W{b[W-1]}}, b};
        sa = a;
        sb = b;
        case (c)
            MDU_OP_MULTU: return {{W{1'b0}}, a} * {{W{1'b0}}, b};
            MDU_OP_MULT:  return pa * pb;
            MDU_OP_DIVU:  return (b == 0) ? {a, {W{1'b1}}} : {a % b, a / b};
            default: begin
                if (b == 0) return {a, {W{1'b1}}};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
                q = sa / sb;
                r = sa % sb;
                return {r, q};
            end
        endcase
    endfunction

    task automatic issue(input logic [5:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        start = 1'b1; alu_ctrl = c; rs_val = a; rt_val = b;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done();
        cycles = 0; busy_cycles = 0; timed_out = 0;
        while (done !== 1'b1 && !timed_out) begin
            if (busy === 1'b1) busy_cycles++;
            @(negedge clk);
            cycles++;
            if (cycles > 200) timed_out = 1;
        end
    endtask

    task automatic run_op(input logic [5:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [2*W-1:0] expv);
        issue(c, a, b);
        exp_q.push_back(expv);
        wait_done();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; flush = 1'b0; hilo_rd = 1'b1;
        alu_ctrl = '0; rs_val = '0; rt_val = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, stall, hi, lo} !== {3'b000, 64'h0}) begin
            failures++;
            $display("FAIL reset_state: busy=%b done=%b stall=%b hi=%h lo=%h want all zero",
                     busy, done, stall, hi, lo);
        end
        hilo_rd = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_multu_latency();
        run_op(MDU_OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, {32'hFFFF_FFFE, 32'h0000_0001});
        checks++;
        if (timed_out || cycles != 33 || busy_cycles != 33) begin
            failures++;
            $display("FAIL multu_latency: done_after=%0d busy_cycles=%0d timeout=%0d want 33/33/0",
                     cycles, busy_cycles, timed_out);
        end
        exp_v = exp_q.pop_front();
        checks++;
        if ({hi, lo} !== exp_v) begin
            failures++;
            $display("FAIL multu_result: got %h_%h want %h", hi, lo, exp_v);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL done_pulse: done=%b busy=%b want 0/0", done, busy);
        end
    endtask

    task automatic test_mult_stall();
        issue(MDU_OP_MULT, 32'hFFFF_FFFD, 32'd5);
        exp_q.push_back({32'hFFFF_FFFF, 32'hFFFF_FFF1});
        hilo_rd = 1'b1;
        #1;
        checks++;
        if (stall !== 1'b1) begin
            failures++;
            $display("FAIL stall_busy: stall=%b want 1", stall);
        end
        @(negedge clk);
        hilo_rd = 1'b0;
        wait_done();
        exp_v = exp_q.pop_front();
        checks++;
        if (timed_out || {hi, lo} !== exp_v) begin
            failures++;
            $display("FAIL mult_result: got %h_%h want %h timeout=%0d", hi, lo, exp_v, timed_out);
        end
        @(negedge clk);
        hilo_rd = 1'b1;
        #1;
        checks++;
        if (stall !== 1'b0) begin
            failures++;
            $display("FAIL stall_idle: stall=%b want 0", stall);
        end
        hilo_rd = 1'b0;
    endtask

    task automatic test_divide();
        logic [5:0]   codes[4] = '{MDU_OP_DIV, MDU_OP_DIVU, MDU_OP_DIV, MDU_OP_DIVU};
        logic [W-1:0] as[4]    = '{32'hFFFF_FFF9, 32'd7, 32'h8000_0000, 32'd5};
        logic [W-1:0] bs[4]    = '{32'd2, 32'd2, 32'hFFFF_FFFF, 32'd0};
        logic [2*W-1:0] ev[4]  = '{{32'hFFFF_FFFF, 32'hFFFF_FFFD}, {32'd1, 32'd3},
                                   {32'd0, 32'h8000_0000}, {32'd5, 32'hFFFF_FFFF}};
        for (int i = 0; i < 4; i++) begin
            run_op(codes[i], as[i], bs[i], ev[i]);
            exp_v = exp_q.pop_front();
            checks++;
            if (timed_out || {hi, lo} !== exp_v) begin
                failures++;
                $display("FAIL div_case%0d: got %h_%h want %h timeout=%0d",
                         i, hi, lo, exp_v, timed_out);
            end
        end
    endtask

    task automatic test_flush();
        int done_seen;
        run_op(MDU_OP_MULTU, 32'd3, 32'd4, {32'd0, 32'd12});
        exp_v = exp_q.pop_front();
        checks++;
        if (timed_out || {hi, lo} !== exp_v) begin
            failures++;
            $display("FAIL flush_setup: got %h_%h want %h", hi, lo, exp_v);
        end
        issue(MDU_OP_MULTU, 32'h1234_5678, 32'h9ABC_DEF0);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL flush_busy: busy=%b want 0", busy);
        end
        done_seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) done_seen++;
        end
        checks++;
        if (done_seen != 0 || {hi, lo} !== {32'd0, 32'd12}) begin
            failures++;
            $display("FAIL flush_hold: activity=%0d hi=%h lo=%h want 0/0/c", done_seen, hi, lo);
        end
    endtask

    task automatic test_start_while_busy();
        issue(MDU_OP_DIVU, 32'd100, 32'd7);
        exp_q.push_back({32'd2, 32'd14});
        repeat (4) @(negedge clk);
        start = 1'b1; alu_ctrl = MDU_OP_MULTU; rs_val = 32'hFFFF_FFFF; rt_val = 32'd2;
        #1;
        checks++;
        if (stall !== 1'b1) begin
            failures++;
            $display("FAIL stall_start: stall=%b want 1", stall);
        end
        @(negedge clk);
        start = 1'b0;
        wait_done();
        exp_v = exp_q.pop_front();
        checks++;
        if (timed_out || {hi, lo} !== exp_v) begin
            failures++;
            $display("FAIL ignored_start_result: got %h_%h want %h", hi, lo, exp_v);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL ignored_start_idle: busy=%b want 0", busy);
        end
    endtask

    task automatic test_reset_mid();
        issue(MDU_OP_MULTU, 32'd7, 32'd9);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, done, hi, lo} !== {2'b00, 64'h0}) begin
            failures++;
            $display("FAIL reset_mid: busy=%b done=%b hi=%h lo=%h want zeros", busy, done, hi, lo);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_invalid_code();
        logic [5:0] bad[3] = '{6'h20, 6'h00, 6'h1C};
        int activity;
        for (int i = 0; i < 3; i++) begin
            activity = 0;
            issue(bad[i], 32'd6, 32'd3);
            repeat (40) begin
                if (busy === 1'b1 || done === 1'b1) activity++;
                @(negedge clk);
            end
            checks++;
            if (activity != 0) begin
                failures++;
                $display("FAIL invalid_code_%h: active_cycles=%0d want 0", bad[i], activity);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [5:0] codes[4] = '{MDU_OP_MULT, MDU_OP_MULTU, MDU_OP_DIV, MDU_OP_DIVU};
        logic [5:0]   c;
        logic [W-1:0] a, b;
        for (int i = 0; i < 10; i++) begin
            c = codes[$urandom_range(0, 3)];
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 9)) : W'($urandom);
            if ($urandom_range(0, 1) == 1) b[W-1] = 1'b1;
            run_op(c, a, b, model(c, a, b));
            exp_v = exp_q.pop_front();
            checks++;
            if (timed_out || {hi, lo} !== exp_v) begin
                failures++;
                $display("FAIL b2b_%0d op=%h a=%h b=%h: got %h_%h want %h",
                         i, c, a, b, hi, lo, exp_v);
            end
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_multu_latency();
        test_mult_stall();
        test_divide();
        test_flush();
        test_start_while_busy();
        test_reset_mid();
        test_invalid_code();
        test_back_to_back();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
